// File: rtl/pattern_generator.sv
// pattern_generator: serializes parallel words accepted over valid/ready onto a
// serial_pattern/enable pair. Each word is framed by enable, followed by a
// programmable number of enable-low gap cycles (none when GAP = 0).
module pattern_generator #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int GAP       = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             serial_pattern,
  output logic             enable,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [3:0]    GAP_M1   = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [3:0]       gap_cnt_q, gap_cnt_d;
  logic             serial_q, serial_d;
  logic             enable_q, enable_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ready_s;
  logic             accept_s;
  logic [WIDTH-1:0] shifted_s;

  // Bit that leaves the word first in the configured direction.
  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // Word advanced by one position so its next bit becomes the first bit.
  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  // Ready when idle, or on the last bit of a word when streaming without a gap.
  always_comb begin
    ready_s = 1'b0;
    if (rst) begin
      ready_s = 1'b0;
    end else if (state_q == ST_IDLE) begin
      ready_s = 1'b1;
    end else if ((state_q == ST_SHIFT) && (bit_cnt_q == '0) && (GAP == 0)) begin
      ready_s = 1'b1;
    end else begin
      ready_s = 1'b0;
    end
  end

  assign accept_s   = data_valid & ready_s;
  assign shifted_s  = shift_word(shift_q);
  assign data_ready = ready_s;

  // State and output registers; reset discards any in-flight word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= 4'd0;
      serial_q  <= 1'b0;
      enable_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      serial_q  <= serial_d;
      enable_q  <= enable_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) state_d = ST_SHIFT;
        else          state_d = ST_IDLE;
      end
      ST_SHIFT: begin
        if (bit_cnt_q != '0)  state_d = ST_SHIFT;
        else if (GAP != 0)    state_d = ST_GAP;
        else if (accept_s)    state_d = ST_SHIFT;
        else                  state_d = ST_IDLE;
      end
      ST_GAP: begin
        if (gap_cnt_q == 4'd0) state_d = ST_IDLE;
        else                   state_d = ST_GAP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and registered-output next values.
  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    serial_d  = 1'b0;
    enable_d  = 1'b0;
    done_d    = 1'b0;
    if (accept_s) begin
      shift_d   = data_in;
      bit_cnt_d = CNT_LAST;
      serial_d  = first_bit(data_in);
      enable_d  = 1'b1;
    end else if ((state_q == ST_SHIFT) && (bit_cnt_q != '0)) begin
      shift_d   = shifted_s;
      bit_cnt_d = bit_cnt_q - CNT_ONE;
      serial_d  = first_bit(shifted_s);
      enable_d  = 1'b1;
      done_d    = (bit_cnt_q == CNT_ONE);
    end else if (state_q == ST_SHIFT) begin
      gap_cnt_d = GAP_M1;
    end else if ((state_q == ST_GAP) && (gap_cnt_q != 4'd0)) begin
      gap_cnt_d = gap_cnt_q - 4'd1;
    end else begin
      gap_cnt_d = gap_cnt_q;
    end
    busy_d = (state_d != ST_IDLE);
  end

  assign serial_pattern = serial_q;
  assign enable         = enable_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: tb/tb_pattern_generator.sv
// Directed bench for pattern_generator: three instances cover MSB-first with a
// one-cycle gap (a), LSB-first with a gap (b) and MSB-first streaming (c).
`timescale 1ns/1ps
module tb_pattern_generator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] d_a = 8'h00, d_b = 8'h00, d_c = 8'h00;
  logic v_a = 1'b0, v_b = 1'b0, v_c = 1'b0;
  logic rdy_a, ser_a, en_a, busy_a, done_a;
  logic rdy_b, ser_b, en_b, busy_b, done_b;
  logic rdy_c, ser_c, en_c, busy_c, done_c;

  int total = 0;
  int bad   = 0;

  pattern_generator #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP(1)) u_a (
    .clk(clk), .rst(rst), .data_in(d_a), .data_valid(v_a), .data_ready(rdy_a),
    .serial_pattern(ser_a), .enable(en_a), .busy(busy_a), .done(done_a));

  pattern_generator #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP(1)) u_b (
    .clk(clk), .rst(rst), .data_in(d_b), .data_valid(v_b), .data_ready(rdy_b),
    .serial_pattern(ser_b), .enable(en_b), .busy(busy_b), .done(done_b));

  pattern_generator #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP(0)) u_c (
    .clk(clk), .rst(rst), .data_in(d_c), .data_valid(v_c), .data_ready(rdy_c),
    .serial_pattern(ser_c), .enable(en_c), .busy(busy_c), .done(done_c));

  // Reference detector on instance a: flags windows of three bits with two ones,
  // forgetting history whenever enable is low.
  logic [1:0] det_hist;
  logic [1:0] det_cnt;
  logic       det_out;
  always_ff @(posedge clk) begin
    if (!en_a) begin
      det_hist <= 2'b00;
      det_cnt  <= 2'd0;
    end else begin
      det_hist <= {det_hist[0], ser_a};
      det_cnt  <= (det_cnt == 2'd2) ? 2'd2 : det_cnt + 2'd1;
    end
  end
  assign det_out = en_a && (det_cnt == 2'd2) && ($countones({det_hist, ser_a}) == 2);

  // Advance one cycle; outputs are observed at the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    // start a word, then hit reset mid-word and mid-cycle
    v_a = 1'b1; d_a = 8'hA5;
    tick();
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    total++;
    if ({rdy_a, ser_a, en_a, busy_a, done_a} !== 5'b00000) begin
      bad++;
      $display("FAIL reset_async got=%b want=00000", {rdy_a, ser_a, en_a, busy_a, done_a});
    end
    @(negedge clk);
    v_a = 1'b0;
    rst = 1'b0;
    tick();
    tick();
    total++;
    if ({rdy_a, ser_a, en_a, busy_a} !== 4'b1000) begin
      bad++;
      $display("FAIL reset_release got=%b want=1000", {rdy_a, ser_a, en_a, busy_a});
    end
  endtask

  task automatic test_single();
    logic [7:0] w;
    w = 8'hA5;
    v_a = 1'b1; d_a = w;
    tick();
    v_a = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      total++;
      if ({en_a, ser_a, done_a, busy_a, rdy_a} !== {1'b1, w[8-k], (k == 8), 1'b1, 1'b0}) begin
        bad++;
        $display("FAIL single_bit k=%0d got=%b want=%b", k, {en_a, ser_a, done_a, busy_a, rdy_a},
                 {1'b1, w[8-k], (k == 8), 1'b1, 1'b0});
      end
      tick();
    end
    total++;
    if ({en_a, ser_a, done_a, busy_a, rdy_a} !== 5'b00010) begin
      bad++;
      $display("FAIL single_gap got=%b want=00010", {en_a, ser_a, done_a, busy_a, rdy_a});
    end
    tick();
    total++;
    if ({en_a, busy_a, rdy_a} !== 3'b001) begin
      bad++;
      $display("FAIL single_ready got=%b want=001", {en_a, busy_a, rdy_a});
    end
  endtask

  task automatic test_direction();
    logic [7:0] lsb_exp, msb_exp;
    lsb_exp = 8'b11110000;  // order of transmission, cycle 1 at bit 7
    msb_exp = 8'b00001111;
    v_a = 1'b1; d_a = 8'h0F;
    v_b = 1'b1; d_b = 8'h0F;
    tick();
    v_a = 1'b0; v_b = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      total++;
      if ({en_b, ser_b, done_b} !== {1'b1, lsb_exp[8-k], (k == 8)}) begin
        bad++;
        $display("FAIL lsb_first k=%0d got=%b want=%b", k, {en_b, ser_b, done_b},
                 {1'b1, lsb_exp[8-k], (k == 8)});
      end
      total++;
      if ({en_a, ser_a} !== {1'b1, msb_exp[8-k]}) begin
        bad++;
        $display("FAIL msb_first k=%0d got=%b want=%b", k, {en_a, ser_a}, {1'b1, msb_exp[8-k]});
      end
      tick();
    end
    tick();
    total++;
    if ({rdy_a, rdy_b, en_a, en_b} !== 4'b1100) begin
      bad++;
      $display("FAIL direction_idle got=%b want=1100", {rdy_a, rdy_b, en_a, en_b});
    end
  endtask

  task automatic test_back_to_back();
    v_c = 1'b1; d_c = 8'hFF;
    tick();
    d_c = 8'h00;
    for (int k = 1; k <= 16; k++) begin
      total++;
      if ({en_c, ser_c, done_c, busy_c} !== {1'b1, (k <= 8), (k == 8 || k == 16), 1'b1}) begin
        bad++;
        $display("FAIL stream k=%0d got=%b want=%b", k, {en_c, ser_c, done_c, busy_c},
                 {1'b1, (k <= 8), (k == 8 || k == 16), 1'b1});
      end
      total++;
      if (rdy_c !== (k == 8 || k == 16)) begin
        bad++;
        $display("FAIL stream_ready k=%0d got=%b want=%b", k, rdy_c, (k == 8 || k == 16));
      end
      if (k == 9) v_c = 1'b0;
      tick();
    end
    total++;
    if ({en_c, ser_c, busy_c, rdy_c} !== 4'b0001) begin
      bad++;
      $display("FAIL stream_end got=%b want=0001", {en_c, ser_c, busy_c, rdy_c});
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] w0, w1;
    w0 = 8'h3C;
    w1 = 8'hC3;
    v_a = 1'b1; d_a = w0;
    tick();
    for (int k = 1; k <= 18; k++) begin
      if (k == 4) d_a = w1;
      if (k <= 8) begin
        total++;
        if ({en_a, ser_a, rdy_a} !== {1'b1, w0[8-k], 1'b0}) begin
          bad++;
          $display("FAIL bp_first k=%0d got=%b want=%b", k, {en_a, ser_a, rdy_a}, {1'b1, w0[8-k], 1'b0});
        end
      end else if (k == 9 || k == 10) begin
        total++;
        if ({en_a, ser_a, rdy_a} !== {1'b0, 1'b0, (k == 10)}) begin
          bad++;
          $display("FAIL bp_gap k=%0d got=%b want=%b", k, {en_a, ser_a, rdy_a}, {1'b0, 1'b0, (k == 10)});
        end
      end else begin
        total++;
        if ({en_a, ser_a, done_a} !== {1'b1, w1[18-k], (k == 18)}) begin
          bad++;
          $display("FAIL bp_second k=%0d got=%b want=%b", k, {en_a, ser_a, done_a},
                   {1'b1, w1[18-k], (k == 18)});
        end
      end
      if (k == 11) v_a = 1'b0;
      tick();
    end
    tick();
  endtask

  task automatic test_loopback();
    logic [7:0] det_exp;
    det_exp = 8'b00111000;  // cycle 1 at bit 7
    v_a = 1'b1; d_a = 8'b01101000;
    tick();
    v_a = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      total++;
      if (det_out !== det_exp[8-k]) begin
        bad++;
        $display("FAIL loopback_det k=%0d got=%b want=%b", k, det_out, det_exp[8-k]);
      end
      tick();
    end
    tick();
    total++;
    if ({det_cnt, det_out, en_a} !== 4'b0000) begin
      bad++;
      $display("FAIL loopback_idle got=%b want=0000", {det_cnt, det_out, en_a});
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({rdy_a, ser_a, en_a, busy_a, done_a} !== 5'b00000) begin
      bad++;
      $display("FAIL reset_hold got=%b want=00000", {rdy_a, ser_a, en_a, busy_a, done_a});
    end
    rst = 1'b0;
    tick();
    test_reset();
    test_single();
    test_direction();
    test_back_to_back();
    test_backpressure();
    test_loopback();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
